// File: rtl/gpu_ram_arbiter_n.sv
// N-port arbiter that funnels single-cycle host read/write pulses onto the single GPU RAM port.
// Every port owns a one-deep pending slot; read data comes back with a per-port ready pulse.
module gpu_ram_arbiter_n #(
    parameter int unsigned PORTS        = 4,
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DELAY_CYCLES = 2,
    parameter int unsigned RR_MODE      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       gpu_data_in,
    input  logic [PORTS-1:0]        wr_ena,
    input  logic [PORTS-1:0]        rd_req,
    input  logic [PORTS*ADDR_W-1:0] address,
    input  logic [PORTS*DATA_W-1:0] data_in,
    output logic                    gpu_wr_ena,
    output logic                    gpu_rd_ena,
    output logic [ADDR_W-1:0]       gpu_address,
    output logic [DATA_W-1:0]       gpu_data_out,
    output logic [PORTS-1:0]        rd_rdy,
    output logic [DATA_W-1:0]       data_out,
    output logic [PORTS-1:0]        busy,
    output logic [PORTS-1:0]        overrun
);

    localparam int unsigned IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0]  pending;
    logic [PORTS-1:0]  pend_wr;
    logic [ADDR_W-1:0] pend_addr [PORTS];
    logic [DATA_W-1:0] pend_data [PORTS];
    logic [IDX_W-1:0]  rr_ptr;

    logic              grant_vld;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;
    logic [PORTS-1:0]  grant_oh;
    logic [PORTS-1:0]  req;
    logic [PORTS-1:0]  accept;
    logic [PORTS-1:0]  drop;

    logic [DELAY_CYCLES-1:0] tag_vld;
    logic [IDX_W-1:0]        tag_idx [DELAY_CYCLES];

    // Search starts one past rr_ptr; in fixed mode rr_ptr never leaves PORTS-1, so port 0 leads.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= PORTS; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % PORTS);
            if (!grant_vld && pending[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // A port may refill its slot in the very cycle the old entry is granted.
    always_comb begin
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
        req    = wr_ena | rd_req;
        accept = req & (~pending | grant_oh);
        drop   = (wr_ena & rd_req) | (req & pending & ~grant_oh);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            pend_wr <= '0;
            overrun <= '0;
            for (int unsigned p = 0; p < PORTS; p++) begin
                pend_addr[p] <= '0;
                pend_data[p] <= '0;
            end
        end else begin
            pending <= accept | (pending & ~grant_oh);
            overrun <= drop;
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (accept[p]) begin
                    pend_wr[p]   <= wr_ena[p];
                    pend_addr[p] <= address[p*ADDR_W +: ADDR_W];
                    pend_data[p] <= data_in[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign busy = pending;

    // Issue stage: one strobe per grant, address/data hold between grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpu_wr_ena   <= 1'b0;
            gpu_rd_ena   <= 1'b0;
            gpu_address  <= '0;
            gpu_data_out <= '0;
            rr_ptr       <= IDX_W'(PORTS - 1);
        end else begin
            gpu_wr_ena <= grant_vld && pend_wr[grant_idx];
            gpu_rd_ena <= grant_vld && !pend_wr[grant_idx];
            if (grant_vld) begin
                gpu_address <= pend_addr[grant_idx];
                if (pend_wr[grant_idx]) begin
                    gpu_data_out <= pend_data[grant_idx];
                end
                if (RR_MODE != 0) begin
                    rr_ptr <= grant_idx;
                end
            end
        end
    end

    // Tag stage 0 loads alongside gpu_rd_ena, so rd_rdy lands DELAY_CYCLES after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld <= '0;
            rd_rdy  <= '0;
            for (int unsigned i = 0; i < DELAY_CYCLES; i++) begin
                tag_idx[i] <= '0;
            end
        end else begin
            tag_vld[0] <= grant_vld && !pend_wr[grant_idx];
            tag_idx[0] <= grant_idx;
            for (int unsigned i = 1; i < DELAY_CYCLES; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
            rd_rdy <= '0;
            if (tag_vld[DELAY_CYCLES-1]) begin
                rd_rdy[tag_idx[DELAY_CYCLES-1]] <= 1'b1;
            end
        end
    end

    assign data_out = gpu_data_in;

endmodule

// File: tb/tb_gpu_ram_arbiter_n.sv
// Bench for gpu_ram_arbiter_n: fixed-priority and round-robin instances share stimulus,
// each is checked every cycle against its own transaction-level model.
module tb_gpu_ram_arbiter_n;

    localparam int unsigned P  = 4;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 8;
    localparam int unsigned D  = 2;

    logic clk = 1'b0;
    logic reset;
    logic [P-1:0]    wr_ena, rd_req;
    logic [P*AW-1:0] address;
    logic [P*DW-1:0] data_in;

    logic [DW-1:0] gdi    [2];
    logic          g_wr   [2];
    logic          g_rd   [2];
    logic [AW-1:0] g_addr [2];
    logic [DW-1:0] g_dout [2];
    logic [DW-1:0] g_dat  [2];
    logic [P-1:0]  g_rdy  [2];
    logic [P-1:0]  g_busy [2];
    logic [P-1:0]  g_ovr  [2];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        gpu_ram_arbiter_n #(
            .PORTS(P), .ADDR_W(AW), .DATA_W(DW), .DELAY_CYCLES(D), .RR_MODE(m)
        ) u_dut (
            .clk(clk), .reset(reset), .gpu_data_in(gdi[m]),
            .wr_ena(wr_ena), .rd_req(rd_req), .address(address), .data_in(data_in),
            .gpu_wr_ena(g_wr[m]), .gpu_rd_ena(g_rd[m]), .gpu_address(g_addr[m]),
            .gpu_data_out(g_dout[m]), .rd_rdy(g_rdy[m]), .data_out(g_dat[m]),
            .busy(g_busy[m]), .overrun(g_ovr[m])
        );
    end

    // Reference model: request slots per port, grant by rule, read returns scheduled by cycle.
    bit            pv [2][P];
    bit            pt [2][P];
    logic [AW-1:0] pa [2][P];
    logic [DW-1:0] pd [2][P];
    int            ptr [2];
    logic          e_wr [2];
    logic          e_rd [2];
    logic [AW-1:0] e_addr [2];
    logic [DW-1:0] e_dout [2];
    logic [DW-1:0] e_dat  [2];
    logic [P-1:0]  e_busy [2];
    logic [P-1:0]  e_ovr  [2];
    logic [P-1:0]  e_rdy  [2];
    bit            rs_v [2][32];
    int            rs_p [2][32];
    logic [DW-1:0] rs_d [2][32];
    logic [DW-1:0] mm   [2][16];
    // RAM environment driving gpu_data_in from what each DUT actually strobed.
    logic [DW-1:0] em   [2][16];
    bit            es_v [2][32];
    logic [DW-1:0] es_d [2][32];

    int cyc, n_cmp, n_bad;
    int n_wr [2];
    int n_rd [2];
    int n_rdy[2];
    int n_ovr[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int grant_of(input int m);
        int g = -1;
        for (int k = 1; k <= int'(P); k++) begin
            int q = (m == 0) ? k - 1 : (ptr[m] + k) % int'(P);
            if (g < 0 && pv[m][q]) g = q;
        end
        return g;
    endfunction

    task automatic model_reset(input int m);
        ptr[m] = int'(P) - 1;
        e_wr[m] = 1'b0; e_rd[m] = 1'b0; e_addr[m] = '0; e_dout[m] = '0; e_dat[m] = '0;
        e_busy[m] = '0; e_ovr[m] = '0; e_rdy[m] = '0;
        for (int p = 0; p < int'(P); p++) pv[m][p] = 1'b0;
        for (int s = 0; s < 32; s++) begin
            rs_v[m][s] = 1'b0;
            es_v[m][s] = 1'b0;
        end
    endtask

    task automatic model_step(input int m, input logic [P-1:0] we, input logic [P-1:0] rr,
                              input logic [P*AW-1:0] ad, input logic [P*DW-1:0] di);
        int g;
        int slot;
        logic [3:0] ix;
        g = grant_of(m);
        e_wr[m] = 1'b0; e_rd[m] = 1'b0; e_ovr[m] = '0; e_rdy[m] = '0;
        if (g >= 0) begin
            if (m != 0) ptr[m] = g;
            e_addr[m] = pa[m][g];
            ix = pa[m][g][3:0];
            if (pt[m][g]) begin
                e_wr[m] = 1'b1;
                e_dout[m] = pd[m][g];
                mm[m][ix] = pd[m][g];
            end else begin
                e_rd[m] = 1'b1;
                slot = (cyc + int'(D)) % 32;
                rs_v[m][slot] = 1'b1;
                rs_p[m][slot] = g;
                rs_d[m][slot] = mm[m][ix];
            end
        end
        for (int p = 0; p < int'(P); p++) begin
            bit rq = we[p] | rr[p];
            if (we[p] && rr[p]) e_ovr[m][p] = 1'b1;
            if (rq && pv[m][p] && g != p) begin
                e_ovr[m][p] = 1'b1;
            end else if (rq) begin
                pv[m][p] = 1'b1;
                pt[m][p] = we[p];
                pa[m][p] = ad[p*AW +: AW];
                pd[m][p] = di[p*DW +: DW];
            end else if (g == p) begin
                pv[m][p] = 1'b0;
            end
            e_busy[m][p] = pv[m][p];
        end
        slot = cyc % 32;
        if (rs_v[m][slot]) begin
            e_rdy[m] = P'(1) << rs_p[m][slot];
            e_dat[m] = rs_d[m][slot];
            rs_v[m][slot] = 1'b0;
        end
    endtask

    task automatic env_step(input int m);
        int slot;
        if (g_wr[m] === 1'b1) em[m][g_addr[m][3:0]] = g_dout[m];
        if (g_rd[m] === 1'b1) begin
            slot = (cyc + int'(D)) % 32;
            es_v[m][slot] = 1'b1;
            es_d[m][slot] = em[m][g_addr[m][3:0]];
        end
        slot = cyc % 32;
        if (es_v[m][slot]) begin
            gdi[m] = es_d[m][slot];
            es_v[m][slot] = 1'b0;
        end else begin
            gdi[m] = DW'($urandom);
        end
    endtask

    task automatic compare(input int m);
        check($sformatf("m%0d_wr", m),   32'(g_wr[m]),   32'(e_wr[m]));
        check($sformatf("m%0d_rd", m),   32'(g_rd[m]),   32'(e_rd[m]));
        check($sformatf("m%0d_addr", m), 32'(g_addr[m]), 32'(e_addr[m]));
        check($sformatf("m%0d_dout", m), 32'(g_dout[m]), 32'(e_dout[m]));
        check($sformatf("m%0d_busy", m), 32'(g_busy[m]), 32'(e_busy[m]));
        check($sformatf("m%0d_ovr", m),  32'(g_ovr[m]),  32'(e_ovr[m]));
        check($sformatf("m%0d_rdy", m),  32'(g_rdy[m]),  32'(e_rdy[m]));
        if (e_rdy[m] != '0) check($sformatf("m%0d_rdata", m), 32'(g_dat[m]), 32'(e_dat[m]));
    endtask

    task automatic tick();
        logic [P-1:0]    we = wr_ena;
        logic [P-1:0]    rr = rd_req;
        logic [P*AW-1:0] ad = address;
        logic [P*DW-1:0] di = data_in;
        @(posedge clk);
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (reset) model_reset(m);
            else model_step(m, we, rr, ad, di);
        end
        #1;
        for (int m = 0; m < 2; m++) env_step(m);
        #1;
        for (int m = 0; m < 2; m++) begin
            compare(m);
            n_wr[m]  += int'(g_wr[m]);
            n_rd[m]  += int'(g_rd[m]);
            n_rdy[m] += $countones(g_rdy[m]);
            n_ovr[m] += $countones(g_ovr[m]);
        end
    endtask

    task automatic idle();
        wr_ena = '0; rd_req = '0; address = '0; data_in = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) model_reset(m);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_counts();
        for (int m = 0; m < 2; m++) begin
            n_wr[m] = 0; n_rd[m] = 0; n_rdy[m] = 0; n_ovr[m] = 0;
        end
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0;
        for (int m = 0; m < 2; m++) begin
            gdi[m] = '0;
            for (int a = 0; a < 16; a++) begin
                mm[m][a] = '0;
                em[m][a] = '0;
            end
            mm[m][13] = 8'h5A;
            em[m][13] = 8'h5A;
        end
        clear_counts();
        do_reset();
        check("reset_busy", 32'(g_busy[0]), 32'h0);
        check("reset_addr", 32'(g_addr[0]), 32'h0);

        // Uncontended read on port 1.
        rd_req = 4'b0010;
        address[1*AW +: AW] = 20'h0ABCD;
        tick();
        idle();
        check("rd1_busy", 32'(g_busy[0]), 32'h2);
        tick();
        check("rd1_strobe", 32'(g_rd[0]), 32'h1);
        check("rd1_addr", 32'(g_addr[0]), 32'h0ABCD);
        tick();
        tick();
        check("rd1_rdy", 32'(g_rdy[0]), 32'h2);
        check("rd1_data", 32'(g_dat[0]), 32'h5A);
        tick();

        // Four simultaneous writes, fixed priority drains 0..3.
        do_reset();
        wr_ena = '1;
        for (int p = 0; p < int'(P); p++) begin
            address[p*AW +: AW] = AW'(4 + p);
            data_in[p*DW +: DW] = DW'(8'h10 + p);
        end
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("fp_wr%0d", i), 32'(g_wr[0]), 32'h1);
            check($sformatf("fp_data%0d", i), 32'(g_dout[0]), 32'(8'h10 + i));
            check($sformatf("fp_busy%0d", i), 32'(g_busy[0]), 32'((4'hF << (i + 1)) & 4'hF));
        end
        tick();

        // Round-robin: ports 0 and 2 re-request whenever their slot is free or being granted.
        do_reset();
        clear_counts();
        begin
            logic [AW-1:0] prev_addr = '1;
            int n_same = 0;
            for (int c = 0; c < 10; c++) begin
                int g = grant_of(1);
                idle();
                address[0*AW +: AW] = 20'h00100;
                address[2*AW +: AW] = 20'h00200;
                data_in = P*DW'($urandom);
                if (!pv[1][0] || g == 0) wr_ena[0] = 1'b1;
                if (!pv[1][2] || g == 2) wr_ena[2] = 1'b1;
                tick();
                if (g_wr[1]) begin
                    if (g_addr[1] == prev_addr) n_same++;
                    prev_addr = g_addr[1];
                end
            end
            idle();
            check("rr_alternate", 32'(n_same), 32'h0);
            check("rr_no_ovr", 32'(n_ovr[1]), 32'h0);
            check("rr_wr_count", 32'(n_wr[1]), 32'd9);
        end
        tick();
        tick();

        // Second read on port 3 while it waits behind ports 0..2.
        do_reset();
        clear_counts();
        wr_ena = 4'b0111;
        rd_req = 4'b1000;
        address[3*AW +: AW] = 20'h00003;
        tick();
        wr_ena = '0;
        tick();
        idle();
        check("ovr3_fp", 32'(g_ovr[0]), 32'h8);
        check("ovr3_rr", 32'(g_ovr[1]), 32'h8);
        for (int i = 0; i < 6; i++) tick();
        check("ovr3_reads", 32'(n_rd[0]), 32'h1);

        // Write and read on port 0 in one cycle.
        do_reset();
        clear_counts();
        wr_ena = 4'b0001;
        rd_req = 4'b0001;
        address[0*AW +: AW] = 20'h00009;
        data_in[0*DW +: DW] = 8'h77;
        tick();
        idle();
        check("wr_rd_ovr", 32'(g_ovr[0]), 32'h1);
        for (int i = 0; i < 4; i++) tick();
        check("wr_rd_writes", 32'(n_wr[0]), 32'h1);
        check("wr_rd_reads", 32'(n_rd[0]), 32'h0);

        // Reset one cycle after the read strobe discards the return.
        do_reset();
        clear_counts();
        rd_req = 4'b0010;
        address[1*AW +: AW] = 20'h00002;
        tick();
        idle();
        tick();
        check("rst_rd_strobe", 32'(g_rd[0]), 32'h1);
        tick();
        reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) model_reset(m);
        check("rst_out_rd", 32'(g_rd[0]), 32'h0);
        check("rst_out_rdy", 32'(g_rdy[0]), 32'h0);
        check("rst_out_addr", 32'(g_addr[0]), 32'h0);
        check("rst_out_busy", 32'(g_busy[0]), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rst_no_rdy", 32'(n_rdy[0] + n_rdy[1]), 32'h0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int p = 0; p < int'(P); p++) begin
                int r = int'($urandom_range(0, 9));
                if (r < 2 || r == 4) wr_ena[p] = 1'b1;
                if ((r >= 2 && r < 4) || r == 4) rd_req[p] = 1'b1;
                address[p*AW +: AW] = AW'($urandom_range(0, 15));
                data_in[p*DW +: DW] = DW'($urandom);
            end
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpu_ram_arbiter_n.md
Name: gpu_ram_arbiter_n

Overview:
- N-port successor to the two-port GPU RAM data mux.
- Arbitrates single-cycle read/write request pulses from PORTS host interfaces (Z80, RS232, DMA/blitter, ...) onto the single GPU RAM port.
- Per-port pending registers: no request is lost while another port holds the bus.
- Selectable fixed-priority or round-robin grant; read data is returned with a per-port ready pulse after a parametrised RAM latency.

Parameters:
- PORTS, 4: number of requesting ports, 2..8.
- ADDR_W, 20: GPU RAM address width; narrower hosts zero-extend externally.
- DATA_W, 8: data width.
- DELAY_CYCLES, 2: GPU RAM read latency, measured from the cycle gpu_rd_ena is high to the cycle gpu_data_in is valid; 1..8.
- RR_MODE, 0: 0 = fixed priority (port 0 highest); 1 = round-robin.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- gpu_data_in  in  DATA_W  read data from GPU RAM.
- wr_ena  in  PORTS  per-port write request pulse.
- rd_req  in  PORTS  per-port read request pulse.
- address  in  PORTS*ADDR_W  per-port address; port p occupies bits [p*ADDR_W +: ADDR_W].
- data_in  in  PORTS*DATA_W  per-port write data; same packing scheme.
- gpu_wr_ena  out  1  one-clock write strobe to GPU RAM.
- gpu_rd_ena  out  1  one-clock read strobe to GPU RAM.
- gpu_address  out  ADDR_W  GPU RAM address.
- gpu_data_out  out  DATA_W  GPU RAM write data.
- rd_rdy  out  PORTS  one-clock pulse: data_out is valid for port p.
- data_out  out  DATA_W  shared read data; combinationally equal to gpu_data_in.
- busy  out  PORTS  port p has a pending, not-yet-granted request.
- overrun  out  PORTS  one-clock pulse: a request on port p was dropped.

Behaviour:
- Reset (async): all pending flags, rd_rdy, overrun, gpu_wr_ena, gpu_rd_ena and the read tag pipeline go to 0. gpu_address and gpu_data_out go to 0. Round-robin pointer goes to PORTS-1, so port 0 wins first. Reset mid-transfer discards in-flight reads; no rd_rdy follows.
- Capture, at the edge after a request cycle:
  - If wr_ena[p] or rd_req[p] is high and port p has no pending request, latch type, address and data, and set pending[p].
  - wr_ena and rd_req both high on one port in one cycle: write captured, read dropped, overrun[p] pulses.
  - Request while pending[p] is set and not granted that same edge: dropped, overrun[p] pulses, pending contents unchanged.
  - Request in the cycle its pending entry is granted: accepted; pending[p] stays set with the new contents.
- busy[p] = pending[p] (registered).
- Arbitration, at most one grant per cycle:
  - RR_MODE=0: lowest-index pending port wins.
  - RR_MODE=1: search starts at pointer+1 mod PORTS; the pointer updates to the granted port on each grant.
- Issue, at the edge when port g is granted:
  - gpu_address takes the latched address.
  - Write: gpu_data_out takes the latched data and gpu_wr_ena=1 for exactly one cycle.
  - Read: gpu_rd_ena=1 for exactly one cycle; gpu_data_out holds its previous value.
  - Both strobes are 0 in cycles with no grant. gpu_address and gpu_data_out hold between grants.
- Latency: request in cycle 0 → pending at edge 1 → strobe high in cycle 2 (uncontended). A port that loses arbitration waits whole cycles; with round-robin, the worst-case wait is PORTS-1 grants.
- Read return:
  - Tag pipeline of DELAY_CYCLES stages carries {valid, port index}; an entry is pushed when gpu_rd_ena is asserted.
  - rd_rdy[idx] pulses for one cycle when the entry reaches the final stage, i.e. DELAY_CYCLES cycles after gpu_rd_ena.
  - Back-to-back reads return back-to-back, in grant order. Writes never produce rd_rdy.
- Sustained throughput is one transaction per clock. Reads and writes may interleave freely; GPU RAM is true single-port with a fixed latency.

Test Plan:
- Reset, then port 1 rd_req at addr 0x0ABCD, gpu_data_in model returns 0x5A → gpu_rd_ena in cycle 2, gpu_address=0x0ABCD, rd_rdy=0b0010 in cycle 4 (DELAY_CYCLES=2), data_out=0x5A.
- RR_MODE=0, ports 0..3 write simultaneously with data 0x10..0x13 → four consecutive gpu_wr_ena pulses in order 0,1,2,3; busy clears per port on its grant.
- RR_MODE=1, ports 0 and 2 request every cycle after their grants → grants alternate 0,2,0,2; no overrun.
- Port 3 issues a second rd_req while busy[3]=1 and not granted → overrun=0b1000 for one cycle; only one read reaches RAM.
- Port 0 wr_ena and rd_req in the same cycle → one gpu_wr_ena, no gpu_rd_ena, overrun[0] pulses.
- Assert reset one cycle after gpu_rd_ena → no rd_rdy afterwards; all outputs 0 while reset is high.
